// File: rtl/common_types.sv
// Types and sizes shared between the CPU memory path (cpuunit) and its arbiter.
package common_types;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 8;

  typedef logic [MEM_DATA_W-1:0] data_t;
  typedef logic                  port_t;

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: one-hot grant plus the id of the winner.
module rr_pick2
  import common_types::*;
(
  input  logic [1:0] req,
  input  port_t      last,
  input  logic       mask0,
  output logic [1:0] gnt,
  output port_t      id
);

  logic [1:0] eligible;

  always_comb begin
    // NOTE: gnt is given a default before the case so every path assigns it and no latch is inferred.
    gnt      = 2'b00;
    eligible = {req[1], req[0] & ~mask0};
    case (eligible)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == 1'b1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    id = port_t'(gnt[1]);
  end

endmodule

// File: rtl/memarb.sv
// Round-robin arbiter sharing the single synchronous-read CPU RAM port between
// the CPU bus (port 0) and the debug/loader (port 1), with a port-1 bus lock.
module memarb
  import common_types::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state, state_next;
  port_t      last;
  port_t      pick_id;
  logic [1:0] pick_gnt;
  logic       in_lock;

  assign in_lock = (state == LOCK1);
  assign locked  = in_lock;

  rr_pick2 u_pick (
    .req   (req),
    .last  (last),
    .mask0 (in_lock),
    .gnt   (pick_gnt),
    .id    (pick_id)
  );

  // Reset suppresses the grant so nothing reaches the RAM while rst is high.
  assign gnt = rst ? 2'b00 : pick_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[1]) begin
      mem_en    = 1'b1;
      mem_we    = we[1];
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end else if (gnt[0]) begin
      mem_en    = 1'b1;
      mem_we    = we[0];
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end
  end

  // Lock is taken only together with a port-1 grant and released as soon as lock1 drops.
  always_comb begin
    state_next = state;
    unique case (state)
      ARB:     if (gnt[1] && lock1) state_next = LOCK1;
      LOCK1:   if (!lock1)          state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state  <= ARB;
      last   <= 1'b1;
      rvalid <= 2'b00;
    end else begin
      state  <= state_next;
      if (|gnt) last <= pick_id;
      rvalid <= gnt & ~we;
    end
  end

  // The RAM presents read data in the cycle after the grant, which is exactly when rvalid is set.
  assign rdata = (|rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_memarb.sv
// Directed-vector and model-checked random bench for memarb.
module tb_memarb;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, we;
  logic [8:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       lock1;
  logic [1:0] gnt, rvalid;
  logic [7:0] rdata;
  logic       locked, mem_en, mem_we;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  memarb dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .lock1     (lock1),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .locked    (locked),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous-read RAM model.
  logic [7:0] ram [512];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    logic       rst;
    logic [1:0] req, we;
    logic [8:0] a0, a1;
    logic [7:0] d0, d1;
    logic       lk;
    logic [1:0] gnt, rv;
    logic [7:0] rd;
    logic       lkd, mwe;
    logic [8:0] maddr;
    logic [7:0] mwd;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [1:0] rq, input logic [1:0] w,
                             input logic [8:0] a0, input logic [8:0] a1,
                             input logic [7:0] d0, input logic [7:0] d1, input logic lk,
                             input logic [1:0] g, input logic [1:0] rv, input logic [7:0] rd,
                             input logic lkd, input logic mwe, input logic [8:0] ma,
                             input logic [7:0] mwd);
    vec_t t;
    t.rst = r;  t.req = rq; t.we = w;  t.a0 = a0;  t.a1 = a1;  t.d0 = d0; t.d1 = d1;
    t.lk = lk;  t.gnt = g;  t.rv = rv; t.rd = rd;  t.lkd = lkd; t.mwe = mwe;
    t.maddr = ma; t.mwd = mwd;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] w,
                       input logic [8:0] a0, input logic [8:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1, input logic lk);
    rst = r; req = rq; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1; lock1 = lk;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  // Reference model state for the random phase.
  logic       m_locked, m_last;
  logic [1:0] m_rv;
  logic [7:0] m_rd;
  logic [7:0] shadow [512];

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 8'(i) + 8'h11;
    mem_rdata = 8'h00;
    drive(1'b1, 2'b00, 2'b00, 9'h0, 9'h0, 8'h0, 8'h0, 1'b0);

    // RAM preload: byte at address a is a[7:0] + 0x11.
    //          rst req  we   addr0   addr1   wd0    wd1    lk    gnt   rv    rdata  lkd   mwe   maddr   mwd
    vecs.push_back(v(1, 2'b11, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 0, 2'b00, 2'b00, 8'h00, 0, 0, 9'h000, 8'h00));
    vecs.push_back(v(0, 2'b01, 2'b00, 9'h0A0, 9'h000, 8'h00, 8'h00, 0, 2'b01, 2'b00, 8'h00, 0, 0, 9'h0A0, 8'h00));
    vecs.push_back(v(0, 2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 0, 2'b00, 2'b01, 8'hB1, 0, 0, 9'h000, 8'h00));
    vecs.push_back(v(1, 2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 0, 2'b00, 2'b00, 8'h00, 0, 0, 9'h000, 8'h00));
    vecs.push_back(v(0, 2'b11, 2'b00, 9'h001, 9'h002, 8'h00, 8'h00, 0, 2'b01, 2'b00, 8'h00, 0, 0, 9'h001, 8'h00));
    vecs.push_back(v(0, 2'b11, 2'b00, 9'h001, 9'h002, 8'h00, 8'h00, 0, 2'b10, 2'b01, 8'h12, 0, 0, 9'h002, 8'h00));
    vecs.push_back(v(0, 2'b11, 2'b00, 9'h001, 9'h002, 8'h00, 8'h00, 0, 2'b01, 2'b10, 8'h13, 0, 0, 9'h001, 8'h00));
    vecs.push_back(v(0, 2'b11, 2'b00, 9'h001, 9'h002, 8'h00, 8'h00, 0, 2'b10, 2'b01, 8'h12, 0, 0, 9'h002, 8'h00));
    vecs.push_back(v(0, 2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 0, 2'b00, 2'b10, 8'h13, 0, 0, 9'h000, 8'h00));
    vecs.push_back(v(0, 2'b10, 2'b10, 9'h000, 9'h100, 8'h00, 8'hA5, 1, 2'b10, 2'b00, 8'h00, 0, 1, 9'h100, 8'hA5));
    vecs.push_back(v(0, 2'b11, 2'b11, 9'h050, 9'h101, 8'h77, 8'hA6, 1, 2'b10, 2'b00, 8'h00, 1, 1, 9'h101, 8'hA6));
    vecs.push_back(v(0, 2'b11, 2'b11, 9'h050, 9'h102, 8'h77, 8'hA7, 1, 2'b10, 2'b00, 8'h00, 1, 1, 9'h102, 8'hA7));
    vecs.push_back(v(0, 2'b11, 2'b11, 9'h050, 9'h103, 8'h77, 8'hA8, 1, 2'b10, 2'b00, 8'h00, 1, 1, 9'h103, 8'hA8));
    vecs.push_back(v(0, 2'b11, 2'b11, 9'h050, 9'h103, 8'h77, 8'hA8, 0, 2'b10, 2'b00, 8'h00, 1, 1, 9'h103, 8'hA8));
    vecs.push_back(v(0, 2'b11, 2'b11, 9'h050, 9'h103, 8'h77, 8'hA8, 0, 2'b01, 2'b00, 8'h00, 0, 1, 9'h050, 8'h77));
    vecs.push_back(v(0, 2'b01, 2'b01, 9'h1FF, 9'h000, 8'h5A, 8'h00, 0, 2'b01, 2'b00, 8'h00, 0, 1, 9'h1FF, 8'h5A));
    vecs.push_back(v(0, 2'b01, 2'b00, 9'h1FF, 9'h000, 8'h00, 8'h00, 0, 2'b01, 2'b00, 8'h00, 0, 0, 9'h1FF, 8'h00));
    vecs.push_back(v(0, 2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 0, 2'b00, 2'b01, 8'h5A, 0, 0, 9'h000, 8'h00));
    vecs.push_back(v(0, 2'b10, 2'b00, 9'h000, 9'h100, 8'h00, 8'h00, 0, 2'b10, 2'b00, 8'h00, 0, 0, 9'h100, 8'h00));
    vecs.push_back(v(0, 2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 0, 2'b00, 2'b10, 8'hA5, 0, 0, 9'h000, 8'h00));
    vecs.push_back(v(0, 2'b01, 2'b00, 9'h0A0, 9'h000, 8'h00, 8'h00, 1, 2'b01, 2'b00, 8'h00, 0, 0, 9'h0A0, 8'h00));
    vecs.push_back(v(0, 2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 1, 2'b00, 2'b01, 8'hB1, 0, 0, 9'h000, 8'h00));
    vecs.push_back(v(0, 2'b11, 2'b00, 9'h001, 9'h002, 8'h00, 8'h00, 0, 2'b10, 2'b00, 8'h00, 0, 0, 9'h002, 8'h00));
    vecs.push_back(v(0, 2'b11, 2'b00, 9'h001, 9'h002, 8'h00, 8'h00, 0, 2'b01, 2'b10, 8'h13, 0, 0, 9'h001, 8'h00));
    vecs.push_back(v(1, 2'b01, 2'b00, 9'h001, 9'h002, 8'h00, 8'h00, 0, 2'b00, 2'b01, 8'h12, 0, 0, 9'h000, 8'h00));
    vecs.push_back(v(0, 2'b11, 2'b00, 9'h001, 9'h002, 8'h00, 8'h00, 0, 2'b01, 2'b00, 8'h00, 0, 0, 9'h001, 8'h00));
    vecs.push_back(v(0, 2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 0, 2'b00, 2'b01, 8'h12, 0, 0, 9'h000, 8'h00));

    next_cycle();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1,
            vecs[i].d0, vecs[i].d1, vecs[i].lk);
      #3;
      check($sformatf("vec%0d gnt", i),    64'(gnt),       64'(vecs[i].gnt));
      check($sformatf("vec%0d rvalid", i), 64'(rvalid),    64'(vecs[i].rv));
      check($sformatf("vec%0d rdata", i),  64'(rdata),     64'(vecs[i].rd));
      check($sformatf("vec%0d locked", i), 64'(locked),    64'(vecs[i].lkd));
      check($sformatf("vec%0d mem_en", i), 64'(mem_en),    64'(vecs[i].gnt != 2'b00));
      check($sformatf("vec%0d mem_we", i), 64'(mem_we),    64'(vecs[i].mwe));
      check($sformatf("vec%0d addr", i),   64'(mem_addr),  64'(vecs[i].maddr));
      check($sformatf("vec%0d wdata", i),  64'(mem_wdata), 64'(vecs[i].mwd));
      next_cycle();
    end

    // Reset while port 1 holds the lock.
    drive(1'b0, 2'b10, 2'b00, 9'h000, 9'h010, 8'h00, 8'h00, 1'b1);
    #3; check("lkrst take", 64'({gnt, locked}), 64'({2'b10, 1'b0}));
    next_cycle();
    drive(1'b1, 2'b11, 2'b00, 9'h001, 9'h010, 8'h00, 8'h00, 1'b1);
    #3; check("lkrst during", 64'({gnt, locked, rvalid}), 64'({2'b00, 1'b1, 2'b10}));
    next_cycle();
    drive(1'b0, 2'b11, 2'b00, 9'h001, 9'h010, 8'h00, 8'h00, 1'b0);
    #3; check("lkrst after", 64'({gnt, locked, rvalid}), 64'({2'b01, 1'b0, 2'b00}));
    next_cycle();

    // Random phase against a reference model; requests are held until granted.
    drive(1'b1, 2'b00, 2'b00, 9'h000, 9'h000, 8'h00, 8'h00, 1'b0);
    next_cycle();
    rst = 1'b0;
    m_locked = 1'b0; m_last = 1'b1; m_rv = 2'b00; m_rd = 8'h00;
    for (int i = 0; i < 512; i++) shadow[i] = ram[i];
    begin
      logic [1:0] elig, eg, prev_gnt;
      logic [8:0] ea;
      logic [7:0] ed;
      logic       ewe;
      int         wait0, wait1;
      prev_gnt = 2'b11;
      req = 2'b00;
      wait0 = 0; wait1 = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
        if (!(req[0] && !prev_gnt[0])) begin
          req[0] = 1'($urandom_range(0, 1));
          we[0]  = 1'($urandom_range(0, 1));
          addr0  = 9'($urandom_range(0, 15));
          wdata0 = 8'($urandom);
        end
        if (!(req[1] && !prev_gnt[1])) begin
          req[1] = 1'($urandom_range(0, 1));
          we[1]  = 1'($urandom_range(0, 1));
          addr1  = 9'($urandom_range(0, 15));
          wdata1 = 8'($urandom);
        end
        if ($urandom_range(0, 3) == 0) lock1 = ~lock1;
        #3;
        elig = req;
        if (m_locked) elig[0] = 1'b0;
        if (elig == 2'b11) eg = m_last ? 2'b01 : 2'b10;
        else               eg = elig;
        ea  = eg[1] ? addr1  : (eg[0] ? addr0  : 9'h000);
        ed  = eg[1] ? wdata1 : (eg[0] ? wdata0 : 8'h00);
        ewe = eg[1] ? we[1]  : (eg[0] ? we[0]  : 1'b0);
        check($sformatf("rnd%0d outputs", cyc),
              64'({gnt, rvalid, rdata, locked, mem_en, mem_we, mem_addr, mem_wdata}),
              64'({eg, m_rv, (m_rv != 2'b00) ? m_rd : 8'h00, m_locked, eg != 2'b00, ewe, ea, ed}));
        check($sformatf("rnd%0d onehot", cyc), 64'(gnt == 2'b11), 64'(0));
        check($sformatf("rnd%0d gnt_without_req", cyc), 64'(gnt & ~req), 64'(0));
        if (req[0] && !gnt[0] && !m_locked) wait0++; else wait0 = 0;
        if (req[1] && !gnt[1]) wait1++; else wait1 = 0;
        check($sformatf("rnd%0d starvation", cyc), 64'((wait0 > 1) || (wait1 > 1)), 64'(0));
        // Advance the model to the next cycle.
        m_rv = eg & ~we;
        if (eg != 2'b00) begin
          if (ewe) shadow[ea] = ed;
          else     m_rd = shadow[ea];
          m_last = eg[1];
        end
        if (!m_locked) m_locked = eg[1] & lock1;
        else           m_locked = lock1;
        prev_gnt = gnt;
        next_cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memarb.md
# memarb

Two-port arbiter for the single 512×8 CPU memory.
- It shares one synchronous-read RAM port between the CPU bus interface (port 0) and the debug/loader interface (port 1).
- Arbitration is round-robin, with an optional bus lock that gives port 1 exclusive access for multi-byte loads.
- It sits between the cpuunit memory interface and the memory array, and replaces direct array indexing once memory becomes a shared resource.

## Interface
- ADDR_W, 9, memory address width (512 bytes)
- DATA_W, 8, data width (matches data_t)
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- req[1:0]  input  2  access request per port; held until granted
- we[1:0]  input  2  per-port write enable; 1 = write, 0 = read
- addr0, addr1  input  ADDR_W  per-port address
- wdata0, wdata1  input  DATA_W  per-port write data
- lock1  input  1  port 1 bus-lock request
- gnt[1:0]  output  2  combinational accept pulse; at most one bit set
- rvalid[1:0]  output  2  registered read-data-valid, one cycle after the read grant
- rdata  output  DATA_W  read data; valid only while some rvalid bit is set
- locked  output  1  port 1 currently owns the bus
- mem_en, mem_we  output  1 each  RAM enable and write strobe
- mem_addr  output  ADDR_W  RAM address
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM read data, valid one cycle after mem_en with mem_we=0

## Operation
- States:
  - ARB (reset state): round-robin between the ports.
  - LOCK1: port 1 exclusive.
- ARB arbitration:
  - If exactly one req is set, that port is granted.
  - If both are set, the port other than `last` is granted.
  - `last` is updated to the granted port on every grant.
  - Reset value of `last` is 1, so port 0 wins the first contention.
- ARB → LOCK1 when gnt[1]=1 and lock1=1 in the same cycle.
- LOCK1 behaviour:
  - gnt[0] is forced to 0.
  - req[1] is granted every cycle it is set.
  - `last` is held at 1.
- LOCK1 → ARB when lock1=0; this is sampled every cycle, whether or not there is a request. Port 0 can be granted from the cycle after lock1 falls.
- locked = (state == LOCK1), registered.
- Grant datapath:
  - A grant drives mem_en=1, and mem_we/mem_addr/mem_wdata from the granted port in the same cycle.
  - With no grant, mem_en=0, mem_we=0, and mem_addr/mem_wdata = 0.
- A read grant in cycle N sets rvalid[p]=1 in cycle N+1, with rdata = mem_rdata. A write grant produces no rvalid.
- At most one access is accepted per cycle. Back-to-back grants are permitted, so throughput is 1 access/cycle.
- A requester with req=0 is never granted, regardless of `last` or lock state.
- lock1 asserted without a port-1 grant has no effect.

## Timing
- Reset values:
  - state=ARB, last=1, rvalid=0, locked=0, rdata=0.
  - gnt, mem_en, mem_we, mem_addr and mem_wdata are 0 while rst=1 (rst gates the combinational grant).
- Grant latency is 0 cycles from req. Read-data latency is 1 cycle from gnt.
- Reset mid-operation:
  - A read granted in the cycle rst is asserted produces no rvalid.
  - rst during LOCK1 returns to ARB with locked=0 on the next cycle.
- Simultaneous events:
  - Both ports request with `last`=0 → port 1 granted; the next contended cycle grants port 0.
  - A read by one port in cycle N and a grant to the other port in cycle N+1 are independent. rvalid for N and gnt for N+1 coexist in cycle N+1.

## Structure
- In common_types:
  - typedef enum `arb_state_t {ARB, LOCK1}`.
  - typedef `port_t` (1 bit).
  - Localparams MEM_ADDR_W=9 and MEM_DATA_W=8, shared with cpuunit.
- One sub-module, `rr_pick2`:
  - Purely combinational.
  - Inputs: req[1:0], last, mask0.
  - Outputs: one-hot gnt and granted id.
  - Instantiated once; the state machine, `last`, and the rvalid pipeline stay in memarb.

## Test plan
- Reset, then req=2'b01, we0=0, addr0=9'h0A0:
  - gnt=01, mem_addr=0A0, mem_en=1.
  - Next cycle: rvalid=01 and rdata = mem model byte at 0A0.
- Both ports hold reads (addr0=001, addr1=002) for 4 cycles:
  - gnt sequence 01,10,01,10.
  - rvalid follows one cycle later with the matching data.
- Port 1 write with lock1=1 to 0x100, then lock1 held for 3 more writes while req0=1:
  - gnt[0]=0 throughout; locked=1 from the cycle after the first grant.
  - lock1 dropped → port 0 granted within 1 cycle.
- Port 0 write we0=1 addr=0x1FF wdata=0x5A, then a read of 0x1FF:
  - mem_we pulses once; read returns 5A; no rvalid for the write.
- Assert rst in the same cycle as a port-0 read grant, and rst during LOCK1:
  - No rvalid on the next cycle; state=ARB, locked=0, last=1.
- Random req/we/lock1 for 10k cycles against a reference model:
  - Never two gnt bits set; never gnt without req.
  - No starvation beyond 1 cycle outside LOCK1.
  - Data matches the model.
